// File: rtl/ex_mc.sv
// Execute stage: logic/shift/add/sub/slt are combinational; DIV/DIVU run a radix-2 restoring loop (DATA_W+1 stall cycles, then one HI/LO write cycle).
// Holds the pipeline through stallreq_o while dividing; flush_i or rst abandons a divide with no HI/LO write.
module ex_mc #(
  parameter int DATA_W    = 32,
  parameter int REGADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           aluOp_i,
  input  logic [DATA_W-1:0]    reg1_i,
  input  logic [DATA_W-1:0]    reg2_i,
  input  logic [REGADDR_W-1:0] wd_i,
  input  logic                 wreg_i,
  input  logic                 flush_i,
  output logic [REGADDR_W-1:0] wd_o,
  output logic                 wreg_o,
  output logic [DATA_W-1:0]    wdata_o,
  output logic                 whilo_o,
  output logic [DATA_W-1:0]    hi_o,
  output logic [DATA_W-1:0]    lo_o,
  output logic                 stallreq_o
);

  localparam int SH_W  = $clog2(DATA_W);
  localparam int CNT_W = SH_W + 1;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_AND  = 4'd1;
  localparam logic [3:0] OP_OR   = 4'd2;
  localparam logic [3:0] OP_XOR  = 4'd3;
  localparam logic [3:0] OP_NOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_ADD  = 4'd8;
  localparam logic [3:0] OP_SUB  = 4'd9;
  localparam logic [3:0] OP_SLT  = 4'd10;
  localparam logic [3:0] OP_SLTU = 4'd11;
  localparam logic [3:0] OP_DIV  = 4'd12;
  localparam logic [3:0] OP_DIVU = 4'd13;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  // quo starts as the dividend magnitude and fills with quotient bits as it shifts out
  typedef struct packed {
    logic [DATA_W-1:0] quo;
    logic [DATA_W-1:0] rem;
    logic [DATA_W-1:0] dvs;
    logic              qneg;
    logic              rneg;
  } div_st_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  div_st_t            div_q, div_d;

  logic               is_div;
  logic               a_neg, b_neg;
  logic [DATA_W-1:0]  a_mag, b_mag;
  logic [SH_W-1:0]    sh;
  logic [DATA_W-1:0]  alu_res;
  logic [DATA_W:0]    trial, diff;

  assign is_div = (aluOp_i == OP_DIV) || (aluOp_i == OP_DIVU);
  assign a_neg  = (aluOp_i == OP_DIV) && reg1_i[DATA_W-1];
  assign b_neg  = (aluOp_i == OP_DIV) && reg2_i[DATA_W-1];
  assign a_mag  = a_neg ? -reg1_i : reg1_i;
  assign b_mag  = b_neg ? -reg2_i : reg2_i;
  assign sh     = reg1_i[SH_W-1:0];

  // Remainder stays below the divisor, so a non-negative diff always fits in DATA_W bits.
  assign trial  = {div_q.rem, div_q.quo[DATA_W-1]};
  assign diff   = trial - {1'b0, div_q.dvs};

  always_comb begin
    alu_res = '0;
    case (aluOp_i)
      OP_NOP:  alu_res = '0;
      OP_AND:  alu_res = reg1_i & reg2_i;
      OP_OR:   alu_res = reg1_i | reg2_i;
      OP_XOR:  alu_res = reg1_i ^ reg2_i;
      OP_NOR:  alu_res = ~(reg1_i | reg2_i);
      OP_SLL:  alu_res = reg2_i << sh;
      OP_SRL:  alu_res = reg2_i >> sh;
      OP_SRA:  alu_res = DATA_W'($signed(reg2_i) >>> sh);
      OP_ADD:  alu_res = reg1_i + reg2_i;
      OP_SUB:  alu_res = reg1_i - reg2_i;
      OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(reg1_i) < $signed(reg2_i))};
      OP_SLTU: alu_res = {{(DATA_W-1){1'b0}}, (reg1_i < reg2_i)};
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    case (state_q)
      IDLE: begin
        if (is_div && !flush_i) begin
          if (reg2_i == '0) begin
            state_d    = DONE;
            div_d.quo  = '1;
            div_d.rem  = reg1_i;
            div_d.qneg = 1'b0;
            div_d.rneg = 1'b0;
          end else begin
            state_d    = BUSY;
            div_d.quo  = a_mag;
            div_d.rem  = '0;
            div_d.dvs  = b_mag;
            div_d.qneg = a_neg ^ b_neg;
            div_d.rneg = a_neg;
            cnt_d      = '0;
          end
        end
      end
      BUSY: begin
        if (flush_i) begin
          state_d = IDLE;
        end else begin
          if (!diff[DATA_W]) begin
            div_d.rem = diff[DATA_W-1:0];
            div_d.quo = {div_q.quo[DATA_W-2:0], 1'b1};
          end else begin
            div_d.rem = trial[DATA_W-1:0];
            div_d.quo = {div_q.quo[DATA_W-2:0], 1'b0};
          end
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_W - 1)) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
    end
  end

  always_comb begin
    wd_o       = wd_i;
    wreg_o     = wreg_i && !is_div;
    wdata_o    = is_div ? '0 : alu_res;
    stallreq_o = 1'b0;
    whilo_o    = 1'b0;
    hi_o       = '0;
    lo_o       = '0;
    case (state_q)
      IDLE: stallreq_o = is_div && !flush_i;
      BUSY: stallreq_o = !flush_i;
      DONE: begin
        if (!flush_i) begin
          whilo_o = 1'b1;
          lo_o    = div_q.qneg ? -div_q.quo : div_q.quo;
          hi_o    = div_q.rneg ? -div_q.rem : div_q.rem;
        end
      end
      default: stallreq_o = 1'b0;
    endcase
    if (rst) begin
      wd_o       = '0;
      wreg_o     = 1'b0;
      wdata_o    = '0;
      stallreq_o = 1'b0;
      whilo_o    = 1'b0;
      hi_o       = '0;
      lo_o       = '0;
    end
  end

endmodule

// File: tb/tb_ex_mc.sv
// Directed bench for ex_mc: a 32-bit and an 8-bit instance on a shared clock and reset.
module tb_ex_mc;

  localparam logic [3:0] NOP = 4'd0, AND = 4'd1, OR = 4'd2, XOR = 4'd3, NOR = 4'd4;
  localparam logic [3:0] SLL = 4'd5, SRL = 4'd6, SRA = 4'd7, ADD = 4'd8, SUB = 4'd9;
  localparam logic [3:0] SLT = 4'd10, SLTU = 4'd11, DIV = 4'd12, DIVU = 4'd13;

  logic        clk;
  logic        rst;

  logic [3:0]  op32;
  logic [31:0] a32, b32;
  logic [4:0]  wd32;
  logic        wr32, fl32;
  logic [4:0]  wd32_o;
  logic        wreg32_o, whilo32_o, stall32_o;
  logic [31:0] wdata32_o, hi32_o, lo32_o;

  logic [3:0]  op8;
  logic [7:0]  a8, b8;
  logic [4:0]  wd8;
  logic        wr8, fl8;
  logic [4:0]  wd8_o;
  logic        wreg8_o, whilo8_o, stall8_o;
  logic [7:0]  wdata8_o, hi8_o, lo8_o;

  int n_cmp = 0;
  int n_bad = 0;

  ex_mc #(.DATA_W(32), .REGADDR_W(5)) dut32 (
    .clk(clk), .rst(rst), .aluOp_i(op32), .reg1_i(a32), .reg2_i(b32),
    .wd_i(wd32), .wreg_i(wr32), .flush_i(fl32),
    .wd_o(wd32_o), .wreg_o(wreg32_o), .wdata_o(wdata32_o), .whilo_o(whilo32_o),
    .hi_o(hi32_o), .lo_o(lo32_o), .stallreq_o(stall32_o)
  );

  ex_mc #(.DATA_W(8), .REGADDR_W(5)) dut8 (
    .clk(clk), .rst(rst), .aluOp_i(op8), .reg1_i(a8), .reg2_i(b8),
    .wd_i(wd8), .wreg_i(wr8), .flush_i(fl8),
    .wd_o(wd8_o), .wreg_o(wreg8_o), .wdata_o(wdata8_o), .whilo_o(whilo8_o),
    .hi_o(hi8_o), .lo_o(lo8_o), .stallreq_o(stall8_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Single-cycle op on the 32-bit instance; checks data plus {wreg_o, stallreq_o, whilo_o, wd_o}.
  task automatic alu(input string tag, input logic [3:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic wr, input logic [31:0] exp);
    @(posedge clk); #1;
    op32 = op; a32 = a; b32 = b; wd32 = 5'd19; wr32 = wr; fl32 = 1'b0;
    @(negedge clk);
    chk(tag, wdata32_o, exp);
    chk({tag, ".ctl"}, {24'd0, wreg32_o, stall32_o, whilo32_o, wd32_o},
        {24'd0, wr, 1'b0, 1'b0, 5'd19});
  endtask

  // Presents a divide, counts stall cycles, then checks the HI/LO write cycle.
  task automatic run_div(input string tag, input bit w8, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b, input int exp_stall,
                         input logic [31:0] exp_lo, input logic [31:0] exp_hi);
    int stalls;
    logic early;
    @(posedge clk); #1;
    if (w8) begin op8 = op; a8 = a[7:0]; b8 = b[7:0]; wr8 = 1'b1; fl8 = 1'b0; end
    else begin op32 = op; a32 = a; b32 = b; wr32 = 1'b1; fl32 = 1'b0; end
    stalls = 0;
    early  = 1'b0;
    @(negedge clk);
    while ((w8 ? stall8_o : stall32_o) && stalls < 200) begin
      if (w8 ? whilo8_o : whilo32_o) early = 1'b1;
      stalls++;
      @(negedge clk);
    end
    chk({tag, ".stalls"}, stalls, exp_stall);
    chk({tag, ".early_whilo"}, {31'd0, early}, 32'd0);
    if (w8) begin
      chk({tag, ".whilo"}, {31'd0, whilo8_o}, 32'd1);
      chk({tag, ".lo"}, {24'd0, lo8_o}, exp_lo);
      chk({tag, ".hi"}, {24'd0, hi8_o}, exp_hi);
      chk({tag, ".gpr"}, {23'd0, wreg8_o, wdata8_o}, 32'd0);
    end else begin
      chk({tag, ".whilo"}, {31'd0, whilo32_o}, 32'd1);
      chk({tag, ".lo"}, lo32_o, exp_lo);
      chk({tag, ".hi"}, hi32_o, exp_hi);
      chk({tag, ".gpr"}, {31'd0, wreg32_o} | wdata32_o, 32'd0);
    end
  endtask

  task automatic quiet32(input string tag, input int cycles);
    logic seen;
    seen = 1'b0;
    repeat (cycles) begin
      @(negedge clk);
      if (whilo32_o || stall32_o) seen = 1'b1;
    end
    chk(tag, {31'd0, seen}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    op32 = OR; a32 = 32'h1234_0000; b32 = 32'h0000_00FF; wd32 = 5'd7; wr32 = 1'b1; fl32 = 1'b0;
    op8 = DIVU; a8 = 8'd9; b8 = 8'd3; wd8 = 5'd3; wr8 = 1'b1; fl8 = 1'b0;

    // Outputs forced low during reset even with live inputs.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.ctl32", {24'd0, wreg32_o, stall32_o, whilo32_o, wd32_o}, 32'd0);
    chk("rst.wdata32", wdata32_o, 32'd0);
    chk("rst.hilo32", hi32_o | lo32_o, 32'd0);
    chk("rst.ctl8", {24'd0, wreg8_o, stall8_o, whilo8_o, wd8_o}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; op8 = NOP; wr8 = 1'b0;

    alu("or",    OR,   32'h0F0F_0000, 32'h0000_00FF, 1'b1, 32'h0F0F_00FF);
    alu("and",   AND,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0, 32'h00F0_00F0);
    alu("xor",   XOR,  32'hA5A5_A5A5, 32'hFFFF_0000, 1'b1, 32'h5A5A_A5A5);
    alu("nor",   NOR,  32'h0000_0000, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF);
    alu("sra",   SRA,  32'd4,         32'h8000_0000, 1'b1, 32'hF800_0000);
    alu("srl",   SRL,  32'd31,        32'h8000_0000, 1'b1, 32'h0000_0001);
    alu("sll_m", SLL,  32'h0000_0023, 32'h0000_0001, 1'b1, 32'h0000_0008);
    alu("add",   ADD,  32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 32'h0000_0001);
    alu("sub",   SUB,  32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF);
    alu("slt",   SLT,  32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 32'h0000_0001);
    alu("sltu",  SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 32'h0000_0000);
    alu("nop",   NOP,  32'h1111_1111, 32'h2222_2222, 1'b1, 32'h0000_0000);
    alu("op15",  4'd15, 32'h1111_1111, 32'h2222_2222, 1'b1, 32'h0000_0000);

    run_div("divu100_7", 1'b0, DIVU, 32'd100, 32'd7, 33, 32'd14, 32'd2);
    run_div("div_m7_2",  1'b0, DIV, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run_div("div_7_m2",  1'b0, DIV, 32'd7, 32'hFFFF_FFFE, 33, 32'hFFFF_FFFD, 32'd1);
    run_div("div_min",   1'b0, DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000, 32'd0);
    run_div("divu5_0",   1'b0, DIVU, 32'd5, 32'd0, 1, 32'hFFFF_FFFF, 32'd5);

    // Flush with a divide waiting in IDLE: no stall, no start.
    @(posedge clk); #1;
    op32 = DIVU; a32 = 32'd9; b32 = 32'd3; fl32 = 1'b1;
    @(negedge clk);
    chk("flush_idle.stall", {31'd0, stall32_o}, 32'd0);
    @(posedge clk); #1;
    op32 = NOP; fl32 = 1'b0;

    // Flush in the result cycle suppresses the HI/LO write.
    @(posedge clk); #1;
    op32 = DIVU; a32 = 32'd5; b32 = 32'd0;
    @(negedge clk);
    chk("flush_done.stall", {31'd0, stall32_o}, 32'd1);
    @(posedge clk); #1;
    fl32 = 1'b1;
    @(negedge clk);
    chk("flush_done.whilo", {31'd0, whilo32_o}, 32'd0);
    chk("flush_done.lo", lo32_o, 32'd0);
    @(posedge clk); #1;
    op32 = NOP; fl32 = 1'b0;

    // Flush at the tenth BUSY step.
    @(posedge clk); #1;
    op32 = DIVU; a32 = 32'd1000; b32 = 32'd3;
    repeat (10) @(posedge clk);
    #1 fl32 = 1'b1;
    @(negedge clk);
    chk("flush_busy.stall", {31'd0, stall32_o}, 32'd0);
    chk("flush_busy.whilo", {31'd0, whilo32_o}, 32'd0);
    @(posedge clk); #1;
    fl32 = 1'b0; op32 = NOP;
    quiet32("flush_busy.quiet", 40);

    run_div("b2b_1", 1'b0, DIVU, 32'd1000, 32'd10, 33, 32'd100, 32'd0);
    run_div("b2b_2", 1'b0, DIVU, 32'hFFFF_FFFF, 32'd16, 33, 32'h0FFF_FFFF, 32'd15);

    // Reset for two cycles in the middle of a divide.
    @(posedge clk); #1;
    op32 = DIVU; a32 = 32'd100; b32 = 32'd7; wr32 = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("rst_busy.ctl", {24'd0, wreg32_o, stall32_o, whilo32_o, wd32_o}, 32'd0);
      chk("rst_busy.data", wdata32_o | hi32_o | lo32_o, 32'd0);
      @(posedge clk); #1;
    end
    rst = 1'b0; op32 = NOP;
    quiet32("rst_busy.quiet", 40);
    run_div("post_rst", 1'b0, DIVU, 32'd100, 32'd7, 33, 32'd14, 32'd2);
    @(posedge clk); #1;
    op32 = NOP;

    run_div("w8_divu200_3", 1'b1, DIVU, 32'd200, 32'd3, 9, 32'd66, 32'd2);
    run_div("w8_div_min",   1'b1, DIV, 32'h80, 32'hFF, 9, 32'h80, 32'd0);
    run_div("w8_div_m7_2",  1'b1, DIV, 32'hF9, 32'd2, 9, 32'hFD, 32'hFF);
    @(posedge clk); #1;
    op8 = NOP;
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ex_mc.md
Name: ex_mc

Overview:
- Parametrised, multi-cycle execute stage for the in-order integer pipeline. Sits between the id_ex and ex_mem registers.
- Single-cycle ops: logic, shift, add/sub and set-less-than. These are combinational from the operand inputs.
- Signed and unsigned divide: iterative radix-2 unit. Holds the pipeline through stallreq_o and delivers the quotient/remainder pair to the HI/LO write port.

Parameters:
- DATA_W, 32, operand/result width (power of 2, >=8)
- REGADDR_W, 5, destination register address width
- SH_W, $clog2(DATA_W), shift-amount width (derived; not overridden)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- aluOp_i  in  4  opcode: 0 NOP, 1 AND, 2 OR, 3 XOR, 4 NOR, 5 SLL, 6 SRL, 7 SRA, 8 ADD, 9 SUB, 10 SLT, 11 SLTU, 12 DIV, 13 DIVU, 14-15 NOP
- reg1_i  in  DATA_W  operand A (dividend; shift amount in [SH_W-1:0])
- reg2_i  in  DATA_W  operand B (divisor; shift source)
- wd_i  in  REGADDR_W  destination register
- wreg_i  in  1  GPR write request
- flush_i  in  1  pipeline flush; aborts a divide in progress
- wd_o  out  REGADDR_W  destination passthrough
- wreg_o  out  1  GPR write enable
- wdata_o  out  DATA_W  GPR write data
- whilo_o  out  1  HI/LO write enable
- hi_o  out  DATA_W  remainder
- lo_o  out  DATA_W  quotient
- stallreq_o  out  1  hold request to pipeline control

Behaviour:
- Reset: while rst=1, all outputs are 0. On the clock edge with rst=1, state goes to IDLE and the iteration counter and datapath registers go to 0. Reset during a divide aborts it with no HI/LO write.
- Single-cycle ops, combinational, zero latency:
  - wd_o=wd_i; wreg_o=wreg_i; whilo_o=0; stallreq_o=0.
  - ADD/SUB wrap modulo 2^DATA_W. No overflow flag.
  - SLT compares signed; SLTU compares unsigned. Result is 1 or 0, zero-extended.
  - SLL/SRL/SRA shift reg2_i by reg1_i[SH_W-1:0]. SRA sign-fills.
  - NOP and codes 14-15: wdata_o=0; wreg_o=wreg_i.
- DIV/DIVU, all cycles: wreg_o=0 and wdata_o=0. The pipeline holds its inputs stable while stallreq_o=1.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - DIV/DIVU present and flush_i=0 -> stallreq_o=1.
  - Divisor=0 -> next state DONE, with quotient all-ones and remainder = reg1_i.
  - Otherwise -> BUSY. Load magnitudes; for DIV, take two's-complement absolutes. Record the sign of the quotient (signs differ) and of the remainder (dividend sign). Counter=0.
- BUSY:
  - stallreq_o=1. One restoring shift-subtract step per cycle; counter increments.
  - After DATA_W steps -> DONE.
  - flush_i=1 -> IDLE next edge, no HI/LO write; stallreq_o=0 in that cycle.
- DONE:
  - stallreq_o=0 and whilo_o=1.
  - lo_o = quotient, negated if the quotient sign is set. hi_o = remainder, negated if the dividend was negative.
  - Next state IDLE, unconditionally.
  - flush_i in DONE suppresses whilo_o.
- Timing:
  - Nonzero divisor: DIV presented at T -> stall T..T+DATA_W (DATA_W+1 cycles). Result in T+DATA_W+1.
  - Zero divisor: stall 1 cycle; result at T+1.
- Back-to-back divides: the second divide is seen in IDLE the cycle after DONE and starts normally.
- Signed edge case: DIV of most-negative by -1 gives quotient = most-negative and remainder 0 (wraps).
- hi_o and lo_o read 0 whenever whilo_o=0.

Test Plan:
- Reset: rst=1 for 2 cycles mid-BUSY -> all outputs 0, then IDLE. No whilo_o pulse after release.
- Logic/shift/arith, DATA_W=32:
  - OR 0x0F0F0000|0x000000FF -> 0x0F0F00FF.
  - SRA 0x80000000 by 4 -> 0xF8000000.
  - SUB 0 - 1 -> 0xFFFFFFFF.
  - SLT(-1, 1) -> 1; SLTU(-1, 1) -> 0.
  - Each case: wreg_o=wreg_i, stallreq_o=0.
- DIVU 100/7:
  - stallreq_o high exactly 33 cycles.
  - Then one cycle with whilo_o=1, lo_o=14, hi_o=2, wreg_o=0.
- Signed DIV:
  - -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - 0x80000000/-1 -> lo=0x80000000, hi=0.
- Divide by zero: DIVU 5/0 -> 1 stall cycle, then lo=0xFFFFFFFF, hi=5.
- Flush and back-to-back:
  - flush_i at BUSY step 10 -> IDLE next edge, no whilo_o.
  - Two consecutive DIVU -> two results, each after 33 stall cycles, no lost cycle.
- Parameter check: DATA_W=8, DIVU 200/3 -> stall 9 cycles, lo=66, hi=2.
